// File: rtl/serial_frame_pkg_amisha.sv
// Shared types and default parameters for the serial frame receiver.
//  state_e      : receiver FSM states (HUNT for sync search, COLLECT for payload)
//  DEF_*        : default payload width, sync width and sync pattern
package serial_frame_pkg_amisha;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_SYNC_W   = 4;
  localparam logic [3:0]  DEF_SYNC_PAT = 4'b1011;

endpackage

// File: rtl/sync_detect_amisha.sv
// Sync-pattern detector: SYNC_W-bit history shift register plus comparator.
//  clk, rst_n : clock, async active-low reset
//  shift_en   : shift bit_in into the history on this edge
//  clr        : zero the history on this edge (has priority over shift_en)
//  bit_in     : serial bit
//  match_c    : combinational; the history including bit_in equals SYNC_PAT
module sync_detect_amisha
  import serial_frame_pkg_amisha::*;
#(
  parameter int unsigned          SYNC_W   = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0]    SYNC_PAT = DEF_SYNC_PAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic clr,
  input  logic bit_in,
  output logic match_c
);

  logic [SYNC_W-1:0] hist_q;
  logic [SYNC_W-1:0] hist_d;
  logic [SYNC_W-1:0] hist_next_c;

  // The match looks at the history as it will be after this edge, so the
  // sampled bit counts and overlapping prefixes are found naturally.
  always_comb begin
    hist_next_c = {hist_q[SYNC_W-2:0], bit_in};
    hist_d      = hist_q;
    if (clr) begin
      hist_d = '0;
    end else if (shift_en) begin
      hist_d = hist_next_c;
    end
    match_c = shift_en && (hist_next_c == SYNC_PAT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/serial_frame_rx_amisha.sv
// Serial frame receiver: hunts for a sync pattern, deserializes DATA_W bits
// MSB first, and presents each word through a one-entry valid/ready holding
// register with a sticky overrun flag.
//  clk_amisha, reset_amisha : clock, async active-low reset
//  s_in_amisha, en_amisha   : serial bit and its sample strobe
//  data_amisha, valid_amisha, ready_amisha : output word handshake
//  sync_amisha              : high while collecting payload
//  overrun_amisha, clr_ovr_amisha : sticky dropped-word flag and its clear
module serial_frame_rx_amisha
  import serial_frame_pkg_amisha::*;
#(
  parameter int unsigned       DATA_W   = DEF_DATA_W,
  parameter int unsigned       SYNC_W   = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = DEF_SYNC_PAT
) (
  input  logic              clk_amisha,
  input  logic              reset_amisha,
  input  logic              s_in_amisha,
  input  logic              en_amisha,
  output logic [DATA_W-1:0] data_amisha,
  output logic              valid_amisha,
  input  logic              ready_amisha,
  output logic              sync_amisha,
  output logic              overrun_amisha,
  input  logic              clr_ovr_amisha
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic                valid_q, valid_d;
  logic                ovr_q,   ovr_d;

  logic                hunt_shift_c;
  logic                last_bit_c;
  logic                match_c;
  logic [DATA_W-1:0]   word_c;

  assign hunt_shift_c = en_amisha && (state_q == HUNT);
  assign last_bit_c   = en_amisha && (state_q == COLLECT) &&
                        (cnt_q == CNT_W'(DATA_W - 1));
  assign word_c       = {shreg_q[DATA_W-2:0], s_in_amisha};

  // History is cleared at frame end so a new sync cannot reuse payload bits.
  sync_detect_amisha #(
    .SYNC_W   (SYNC_W),
    .SYNC_PAT (SYNC_PAT)
  ) u_sync (
    .clk      (clk_amisha),
    .rst_n    (reset_amisha),
    .shift_en (hunt_shift_c),
    .clr      (last_bit_c),
    .bit_in   (s_in_amisha),
    .match_c  (match_c)
  );

  // Next-state, payload shift and handshake/overrun logic.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    case (state_q)
      HUNT: begin
        if (match_c) begin
          state_d = COLLECT;
          cnt_d   = '0;
        end
      end
      COLLECT: begin
        if (en_amisha) begin
          shreg_d = word_c;
          if (last_bit_c) begin
            state_d = HUNT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = HUNT;
    endcase

    if (clr_ovr_amisha) begin
      ovr_d = 1'b0;
    end

    // A completed word either loads, replaces an accepted word, or is dropped.
    if (!valid_q) begin
      if (last_bit_c) begin
        data_d  = word_c;
        valid_d = 1'b1;
      end
    end else if (ready_amisha) begin
      if (last_bit_c) begin
        data_d = word_c;
      end else begin
        valid_d = 1'b0;
      end
    end else if (last_bit_c) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      state_q <= HUNT;
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_amisha    = data_q;
  assign valid_amisha   = valid_q;
  assign sync_amisha    = (state_q == COLLECT);
  assign overrun_amisha = ovr_q;

endmodule

// File: tb/tb_serial_frame_rx_amisha.sv
// Testbench for serial_frame_rx_amisha: scoreboard of expected words plus
// per-scenario tasks with inline checks.
module tb_serial_frame_rx_amisha;

  logic       clk_amisha = 1'b0;
  logic       reset_amisha;
  logic       s_in_amisha;
  logic       en_amisha;
  logic [7:0] data_amisha;
  logic       valid_amisha;
  logic       ready_amisha;
  logic       sync_amisha;
  logic       overrun_amisha;
  logic       clr_ovr_amisha;

  logic [7:0] exp_q[$];
  int         n_vec  = 0;
  int         n_fail = 0;
  int         xfer_cnt  = 0;
  int         sync_cnt  = 0;
  int         valid_cnt = 0;
  logic [7:0] last_word = 8'h00;

  always #5 clk_amisha = ~clk_amisha;

  serial_frame_rx_amisha dut (
    .clk_amisha     (clk_amisha),
    .reset_amisha   (reset_amisha),
    .s_in_amisha    (s_in_amisha),
    .en_amisha      (en_amisha),
    .data_amisha    (data_amisha),
    .valid_amisha   (valid_amisha),
    .ready_amisha   (ready_amisha),
    .sync_amisha    (sync_amisha),
    .overrun_amisha (overrun_amisha),
    .clr_ovr_amisha (clr_ovr_amisha)
  );

  // Scoreboard monitor: samples mid-low-phase; a transfer happens on the next
  // rising edge when valid and ready are both high here.
  always begin
    logic [7:0] exp;
    @(negedge clk_amisha);
    #3;
    if (reset_amisha && sync_amisha)  sync_cnt++;
    if (reset_amisha && valid_amisha) valid_cnt++;
    if (reset_amisha && valid_amisha && ready_amisha) begin
      xfer_cnt++;
      last_word = data_amisha;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL xfer_spurious: got %h, expected no word", data_amisha);
      end else begin
        exp = exp_q.pop_front();
        if (data_amisha !== exp) begin
          n_fail++;
          $display("FAIL xfer_data: got %h, expected %h", data_amisha, exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive n bits of v MSB first, one per enabled cycle; gap inserts en=0 cycles.
  task automatic send_bits(input logic [31:0] v, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      if (gap) begin
        @(negedge clk_amisha); #1;
        en_amisha   = 1'b0;
        s_in_amisha = 1'($urandom);
      end
      @(negedge clk_amisha); #1;
      en_amisha   = 1'b1;
      s_in_amisha = v[i];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_amisha); #1;
      en_amisha   = 1'b0;
      s_in_amisha = 1'b0;
    end
  endtask

  // Wait (bounded) for all expected words to be consumed.
  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || valid_amisha) && k < 60) begin
      idle(1);
      k++;
    end
    n_vec++;
    if (exp_q.size() != 0 || valid_amisha) begin
      n_fail++;
      $display("FAIL %s_drain: %0d words pending, valid=%b, expected 0 and 0",
               name, exp_q.size(), valid_amisha);
    end
  endtask

  task automatic test_reset;
    reset_amisha   = 1'b0;
    s_in_amisha    = 1'b0;
    en_amisha      = 1'b0;
    ready_amisha   = 1'b0;
    clr_ovr_amisha = 1'b0;
    repeat (2) @(negedge clk_amisha);
    #1;
    n_vec += 4;
    if (data_amisha !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h, expected 00", data_amisha); end
    if (valid_amisha !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", valid_amisha); end
    if (sync_amisha !== 1'b0) begin n_fail++; $display("FAIL rst_sync: got %b, expected 0", sync_amisha); end
    if (overrun_amisha !== 1'b0) begin n_fail++; $display("FAIL rst_ovr: got %b, expected 0", overrun_amisha); end
    reset_amisha = 1'b1;
    idle(2);
  endtask

  task automatic test_reset_mid_frame;
    ready_amisha = 1'b0;
    send_bits({20'h0, 4'b1011, 8'h77}, 12, 1'b0);
    idle(2);
    n_vec += 2;
    if (valid_amisha !== 1'b1) begin n_fail++; $display("FAIL held_valid: got %b, expected 1", valid_amisha); end
    if (data_amisha !== 8'h77) begin n_fail++; $display("FAIL held_data: got %h, expected 77", data_amisha); end
    send_bits({25'h0, 4'b1011, 3'b101}, 7, 1'b0);
    @(negedge clk_amisha); #1;
    en_amisha    = 1'b0;
    reset_amisha = 1'b0;
    #1;
    n_vec += 4;
    if (data_amisha !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h, expected 00", data_amisha); end
    if (valid_amisha !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, expected 0", valid_amisha); end
    if (sync_amisha !== 1'b0) begin n_fail++; $display("FAIL midrst_sync: got %b, expected 0", sync_amisha); end
    if (overrun_amisha !== 1'b0) begin n_fail++; $display("FAIL midrst_ovr: got %b, expected 0", overrun_amisha); end
    @(negedge clk_amisha); #1;
    reset_amisha = 1'b1;
    ready_amisha = 1'b1;
    exp_q.push_back(8'hA5);
    send_bits({20'h0, 4'b1011, 8'hA5}, 12, 1'b0);
    idle(2);
    drain("midrst");
    n_vec++;
    if (last_word !== 8'hA5) begin n_fail++; $display("FAIL midrst_word: got %h, expected a5", last_word); end
  endtask

  task automatic test_basic;
    ready_amisha = 1'b1;
    idle(1);
    sync_cnt  = 0;
    valid_cnt = 0;
    exp_q.push_back(8'hA5);
    send_bits({20'h0, 4'b1011, 8'hA5}, 12, 1'b0);
    idle(4);
    drain("basic");
    n_vec += 3;
    if (sync_cnt != 8) begin n_fail++; $display("FAIL basic_sync_len: got %0d cycles, expected 8", sync_cnt); end
    if (valid_cnt != 1) begin n_fail++; $display("FAIL basic_valid_len: got %0d cycles, expected 1", valid_cnt); end
    if (data_amisha !== 8'hA5) begin n_fail++; $display("FAIL basic_data_hold: got %h, expected a5", data_amisha); end
  endtask

  task automatic test_backpressure;
    ready_amisha = 1'b0;
    exp_q.push_back(8'hA5);
    send_bits({20'h0, 4'b1011, 8'hA5}, 12, 1'b0);
    send_bits({20'h0, 4'b1011, 8'h3C}, 12, 1'b0);
    idle(2);
    n_vec += 3;
    if (data_amisha !== 8'hA5) begin n_fail++; $display("FAIL bp_data: got %h, expected a5", data_amisha); end
    if (valid_amisha !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b, expected 1", valid_amisha); end
    if (overrun_amisha !== 1'b1) begin n_fail++; $display("FAIL bp_ovr_set: got %b, expected 1", overrun_amisha); end
    @(negedge clk_amisha); #1;
    ready_amisha = 1'b1;
    @(negedge clk_amisha); #1;
    ready_amisha = 1'b0;
    n_vec += 2;
    if (valid_amisha !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b, expected 0", valid_amisha); end
    if (overrun_amisha !== 1'b1) begin n_fail++; $display("FAIL bp_ovr_sticky: got %b, expected 1", overrun_amisha); end
    @(negedge clk_amisha); #1;
    clr_ovr_amisha = 1'b1;
    @(negedge clk_amisha); #1;
    clr_ovr_amisha = 1'b0;
    n_vec++;
    if (overrun_amisha !== 1'b0) begin n_fail++; $display("FAIL bp_ovr_clr: got %b, expected 0", overrun_amisha); end
  endtask

  task automatic test_simultaneous;
    ready_amisha = 1'b0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_bits({20'h0, 4'b1011, 8'hA5}, 12, 1'b0);
    send_bits({21'h0, 4'b1011, 7'h1E}, 11, 1'b0);
    @(negedge clk_amisha); #1;
    en_amisha    = 1'b1;
    s_in_amisha  = 1'b0;
    ready_amisha = 1'b1;
    @(negedge clk_amisha); #1;
    en_amisha    = 1'b0;
    ready_amisha = 1'b0;
    n_vec += 3;
    if (overrun_amisha !== 1'b0) begin n_fail++; $display("FAIL sim_ovr: got %b, expected 0", overrun_amisha); end
    if (data_amisha !== 8'h3C) begin n_fail++; $display("FAIL sim_data: got %h, expected 3c", data_amisha); end
    if (valid_amisha !== 1'b1) begin n_fail++; $display("FAIL sim_valid: got %b, expected 1", valid_amisha); end
    ready_amisha = 1'b1;
    drain("sim");
  endtask

  task automatic test_no_overlap;
    ready_amisha = 1'b1;
    idle(1);
    xfer_cnt = 0;
    sync_cnt = 0;
    exp_q.push_back(8'hB0);
    exp_q.push_back(8'h5A);
    send_bits({20'h0, 4'b1011, 8'hB0}, 12, 1'b0);
    send_bits({20'h0, 4'b1011, 8'h5A}, 12, 1'b0);
    idle(12);
    drain("novl");
    n_vec += 2;
    if (xfer_cnt != 2) begin n_fail++; $display("FAIL novl_count: got %0d words, expected 2", xfer_cnt); end
    if (sync_cnt != 16) begin n_fail++; $display("FAIL novl_sync_len: got %0d cycles, expected 16", sync_cnt); end
  endtask

  task automatic test_gaps_false_sync;
    logic [3:0] h;
    logic       b;
    ready_amisha = 1'b1;
    exp_q.push_back(8'hA5);
    send_bits({20'h0, 4'b1011, 8'hA5}, 12, 1'b1);
    idle(2);
    drain("gap");
    n_vec++;
    if (last_word !== 8'hA5) begin n_fail++; $display("FAIL gap_word: got %h, expected a5", last_word); end

    exp_q.push_back(8'h69);
    send_bits({16'h0, 8'b1010_1011, 8'h69}, 16, 1'b0);
    idle(2);
    drain("prefix");
    n_vec++;
    if (last_word !== 8'h69) begin n_fail++; $display("FAIL prefix_word: got %h, expected 69", last_word); end

    valid_cnt = 0;
    sync_cnt  = 0;
    h = 4'b0000;
    for (int i = 0; i < 200; i++) begin
      b = 1'($urandom);
      if ({h[2:0], b} == 4'b1011) b = 1'b0;
      h = {h[2:0], b};
      @(negedge clk_amisha); #1;
      en_amisha   = 1'b1;
      s_in_amisha = b;
    end
    idle(12);
    n_vec += 2;
    if (valid_cnt != 0) begin n_fail++; $display("FAIL nosync_valid: got %0d valid cycles, expected 0", valid_cnt); end
    if (sync_cnt != 0) begin n_fail++; $display("FAIL nosync_sync: got %0d sync cycles, expected 0", sync_cnt); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_basic();
    test_backpressure();
    test_simultaneous();
    test_no_overlap();
    test_gaps_false_sync();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
